// File: rtl/tis_mem_pkg.sv
// Shared widths and requester identifiers for the two-port memory arbiter.
package tis_mem_pkg;

    localparam int ADDR_W_DEF = 15;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic {
        RQ_0 = 1'b0,
        RQ_1 = 1'b1
    } rq_id_t;

endpackage

// File: rtl/tis_rr_arb2.sv
// Two-way pointer-priority arbiter: the pointer names the requester that wins a tie.
module tis_rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    input  logic       en,
    output logic [1:0] gnt
);

    assign gnt[0] = en & req[0] & (~req[1] | ~ptr);
    assign gnt[1] = en & req[1] & (~req[0] |  ptr);

endmodule

// File: rtl/tis_mem_arbiter.sv
// Shares one single-cycle memory port between two requesters, with a one-deep
// read-return pipeline tagged by owner so back-to-back reads never bubble.
module tis_mem_arbiter
    import tis_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  freeze,

    input  logic                  rq0_read,
    input  logic                  rq0_write,
    input  logic [ADDR_W-1:0]     rq0_address,
    input  logic [DATA_W/8-1:0]   rq0_byteenable,
    input  logic [DATA_W-1:0]     rq0_writedata,
    output logic                  rq0_waitrequest,
    output logic [DATA_W-1:0]     rq0_readdata,
    output logic                  rq0_readdatavalid,

    input  logic                  rq1_read,
    input  logic                  rq1_write,
    input  logic [ADDR_W-1:0]     rq1_address,
    input  logic [DATA_W/8-1:0]   rq1_byteenable,
    input  logic [DATA_W-1:0]     rq1_writedata,
    output logic                  rq1_waitrequest,
    output logic [DATA_W-1:0]     rq1_readdata,
    output logic                  rq1_readdatavalid,

    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata,

    output logic [CNT_W-1:0]      grant_cnt0,
    output logic [CNT_W-1:0]      grant_cnt1
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic [1:0]       req;
    logic [1:0]       gnt;
    logic             arb_en;
    logic             any_gnt;
    logic             rd_gnt;
    rq_id_t           win_p0;
    logic             ptr_q;
    logic             vld_p1;
    rq_id_t           owner_p1;
    logic [CNT_W-1:0] cnt0_q;
    logic [CNT_W-1:0] cnt1_q;

    // Stage p0: combinational grant and memory command
    assign req    = {rq1_read | rq1_write, rq0_read | rq0_write};
    assign arb_en = ~freeze & ~reset;

    tis_rr_arb2 u_arb (
        .req (req),
        .ptr (ptr_q),
        .en  (arb_en),
        .gnt (gnt)
    );

    assign any_gnt = |gnt;
    assign win_p0  = gnt[1] ? RQ_1 : RQ_0;
    // A requester asserting both read and write is serviced as a write.
    assign rd_gnt  = (gnt[0] & ~rq0_write) | (gnt[1] & ~rq1_write);

    assign mem_address    = gnt[1] ? rq1_address    : rq0_address;
    assign mem_byteenable = gnt[1] ? rq1_byteenable : rq0_byteenable;
    assign mem_writedata  = gnt[1] ? rq1_writedata  : rq0_writedata;
    assign mem_chipselect = any_gnt;
    assign mem_write      = (gnt[0] & rq0_write) | (gnt[1] & rq1_write);
    assign mem_clken      = ~reset;

    assign rq0_waitrequest = reset | (req[0] & ~gnt[0]);
    assign rq1_waitrequest = reset | (req[1] & ~gnt[1]);

    // Stage p1: read return tagged with its owner
    assign rq0_readdata      = mem_readdata;
    assign rq1_readdata      = mem_readdata;
    assign rq0_readdatavalid = vld_p1 & (owner_p1 == RQ_0);
    assign rq1_readdatavalid = vld_p1 & (owner_p1 == RQ_1);

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q    <= 1'b0;
            vld_p1   <= 1'b0;
            owner_p1 <= RQ_0;
            cnt0_q   <= '0;
            cnt1_q   <= '0;
        end else begin
            vld_p1   <= rd_gnt;
            owner_p1 <= win_p0;
            if (any_gnt) begin
                // Point at the loser so it wins the next tie.
                ptr_q <= gnt[0];
            end
            if (gnt[0]) begin
                cnt0_q <= sat_inc(cnt0_q);
            end
            if (gnt[1]) begin
                cnt1_q <= sat_inc(cnt1_q);
            end
        end
    end

endmodule

// File: tb/tb_tis_mem_arbiter.sv
// Directed bench for tis_mem_arbiter with a one-cycle-latency memory model.
module tb_tis_mem_arbiter;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              freeze;
    logic              rq0_read, rq0_write, rq1_read, rq1_write;
    logic [ADDR_W-1:0] rq0_address, rq1_address;
    logic [3:0]        rq0_byteenable, rq1_byteenable;
    logic [DATA_W-1:0] rq0_writedata, rq1_writedata;
    logic              rq0_waitrequest, rq1_waitrequest;
    logic [DATA_W-1:0] rq0_readdata, rq1_readdata;
    logic              rq0_readdatavalid, rq1_readdatavalid;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_chipselect, mem_write, mem_clken;
    logic [DATA_W-1:0] mem_readdata;
    logic [CNT_W-1:0]  grant_cnt0, grant_cnt1;

    int nvec = 0;
    int nerr = 0;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always #5 clk = ~clk;

    tis_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .freeze(freeze),
        .rq0_read(rq0_read), .rq0_write(rq0_write), .rq0_address(rq0_address),
        .rq0_byteenable(rq0_byteenable), .rq0_writedata(rq0_writedata),
        .rq0_waitrequest(rq0_waitrequest), .rq0_readdata(rq0_readdata),
        .rq0_readdatavalid(rq0_readdatavalid),
        .rq1_read(rq1_read), .rq1_write(rq1_write), .rq1_address(rq1_address),
        .rq1_byteenable(rq1_byteenable), .rq1_writedata(rq1_writedata),
        .rq1_waitrequest(rq1_waitrequest), .rq1_readdata(rq1_readdata),
        .rq1_readdatavalid(rq1_readdatavalid),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_writedata(mem_writedata), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_clken(mem_clken), .mem_readdata(mem_readdata),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    // Synchronous memory: write with byte enables, registered read data.
    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= mem[mem_address];
            end
        end
    end

    task automatic idle();
        rq0_read = 0; rq0_write = 0; rq1_read = 0; rq1_write = 0;
        rq0_address = '0; rq1_address = '0;
        rq0_byteenable = 4'hF; rq1_byteenable = 4'hF;
        rq0_writedata = '0; rq1_writedata = '0;
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1; idle();
        @(negedge clk); reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; freeze = 0; idle();
        rq0_read = 1; rq1_read = 1;
        @(negedge clk); @(negedge clk); #1;
        nvec++; if (rq0_waitrequest !== 1'b1) begin nerr++; $display("FAIL rst_wr0 got %b want 1", rq0_waitrequest); end
        nvec++; if (rq1_waitrequest !== 1'b1) begin nerr++; $display("FAIL rst_wr1 got %b want 1", rq1_waitrequest); end
        nvec++; if ({rq0_readdatavalid, rq1_readdatavalid} !== 2'b00) begin nerr++; $display("FAIL rst_rdv got %b want 00", {rq0_readdatavalid, rq1_readdatavalid}); end
        nvec++; if ({mem_chipselect, mem_write, mem_clken} !== 3'b000) begin nerr++; $display("FAIL rst_mem got %b want 000", {mem_chipselect, mem_write, mem_clken}); end
        nvec++; if ({grant_cnt0, grant_cnt1} !== 32'h0) begin nerr++; $display("FAIL rst_cnt got %h want 0", {grant_cnt0, grant_cnt1}); end
        @(negedge clk); reset = 0; idle(); #1;
        nvec++; if (mem_clken !== 1'b1) begin nerr++; $display("FAIL clken got %b want 1", mem_clken); end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        rq0_write = 1; rq0_address = 15'h0010; rq0_writedata = 32'hDEADBEEF; rq0_byteenable = 4'hF; #1;
        nvec++; if (rq0_waitrequest !== 1'b0) begin nerr++; $display("FAIL wr_wait got %b want 0", rq0_waitrequest); end
        nvec++; if ({mem_chipselect, mem_write} !== 2'b11) begin nerr++; $display("FAIL wr_cmd got %b want 11", {mem_chipselect, mem_write}); end
        nvec++; if (mem_address !== 15'h0010) begin nerr++; $display("FAIL wr_addr got %h want 0010", mem_address); end
        @(negedge clk);
        rq0_write = 0; rq0_read = 1; #1;
        nvec++; if (rq0_waitrequest !== 1'b0) begin nerr++; $display("FAIL rd_wait got %b want 0", rq0_waitrequest); end
        nvec++; if ({mem_chipselect, mem_write} !== 2'b10) begin nerr++; $display("FAIL rd_cmd got %b want 10", {mem_chipselect, mem_write}); end
        nvec++; if (rq0_readdatavalid !== 1'b0) begin nerr++; $display("FAIL wr_no_rdv got %b want 0", rq0_readdatavalid); end
        @(negedge clk); idle(); #1;
        nvec++; if ({rq0_readdatavalid, rq1_readdatavalid} !== 2'b10) begin nerr++; $display("FAIL rd_rdv got %b want 10", {rq0_readdatavalid, rq1_readdatavalid}); end
        nvec++; if (rq0_readdata !== 32'hDEADBEEF) begin nerr++; $display("FAIL rd_data got %h want deadbeef", rq0_readdata); end
        nvec++; if (grant_cnt0 !== 16'd2) begin nerr++; $display("FAIL wr_cnt0 got %0d want 2", grant_cnt0); end
    endtask

    task automatic test_byteenable();
        @(negedge clk);
        rq1_write = 1; rq1_address = 15'h7FFF; rq1_writedata = 32'hFFFFFFFF; rq1_byteenable = 4'hF;
        @(negedge clk);
        rq1_writedata = 32'h12345678; rq1_byteenable = 4'h3; #1;
        nvec++; if (mem_byteenable !== 4'h3) begin nerr++; $display("FAIL be_mux got %h want 3", mem_byteenable); end
        @(negedge clk);
        rq1_write = 0; rq1_read = 1;
        @(negedge clk); idle(); #1;
        nvec++; if ({rq0_readdatavalid, rq1_readdatavalid} !== 2'b01) begin nerr++; $display("FAIL be_rdv got %b want 01", {rq0_readdatavalid, rq1_readdatavalid}); end
        nvec++; if (rq1_readdata !== 32'hFFFF5678) begin nerr++; $display("FAIL be_data got %h want ffff5678", rq1_readdata); end
    endtask

    task automatic test_alternate();
        pulse_reset();
        rq0_read = 1; rq0_address = 15'h0010;
        rq1_read = 1; rq1_address = 15'h7FFF;
        for (int i = 0; i < 8; i++) begin
            #1;
            nvec++; if ({rq1_waitrequest, rq0_waitrequest} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
                begin nerr++; $display("FAIL alt_grant[%0d] got %b", i, {rq1_waitrequest, rq0_waitrequest}); end
            if (i > 0) begin
                nvec++; if ({rq1_readdatavalid, rq0_readdatavalid} !== ((i % 2 == 1) ? 2'b01 : 2'b10))
                    begin nerr++; $display("FAIL alt_rdv[%0d] got %b", i, {rq1_readdatavalid, rq0_readdatavalid}); end
                nvec++; if (mem_readdata !== ((i % 2 == 1) ? 32'hDEADBEEF : 32'hFFFF5678))
                    begin nerr++; $display("FAIL alt_data[%0d] got %h", i, mem_readdata); end
            end
            @(negedge clk);
        end
        idle(); #1;
        nvec++; if ({rq1_readdatavalid, rq0_readdatavalid} !== 2'b10) begin nerr++; $display("FAIL alt_last got %b want 10", {rq1_readdatavalid, rq0_readdatavalid}); end
        nvec++; if (grant_cnt0 !== 16'd4) begin nerr++; $display("FAIL alt_cnt0 got %0d want 4", grant_cnt0); end
        nvec++; if (grant_cnt1 !== 16'd4) begin nerr++; $display("FAIL alt_cnt1 got %0d want 4", grant_cnt1); end
    endtask

    task automatic test_freeze();
        @(negedge clk);
        rq0_read = 1; rq0_address = 15'h0010;
        rq1_read = 1; rq1_address = 15'h7FFF; #1;
        nvec++; if ({rq1_waitrequest, rq0_waitrequest} !== 2'b10) begin nerr++; $display("FAIL frz_pre got %b want 10", {rq1_waitrequest, rq0_waitrequest}); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); freeze = 1; #1;
            nvec++; if ({rq1_waitrequest, rq0_waitrequest, mem_chipselect} !== 3'b110)
                begin nerr++; $display("FAIL frz_wait[%0d] got %b want 110", i, {rq1_waitrequest, rq0_waitrequest, mem_chipselect}); end
            nvec++; if ({rq1_readdatavalid, rq0_readdatavalid} !== ((i == 0) ? 2'b01 : 2'b00))
                begin nerr++; $display("FAIL frz_rdv[%0d] got %b", i, {rq1_readdatavalid, rq0_readdatavalid}); end
            nvec++; if ({grant_cnt0, grant_cnt1} !== {16'd5, 16'd4})
                begin nerr++; $display("FAIL frz_cnt[%0d] got %h want 00050004", i, {grant_cnt0, grant_cnt1}); end
        end
        nvec++; if (rq0_readdata !== 32'hDEADBEEF) begin nerr++; $display("FAIL frz_data got %h want deadbeef", rq0_readdata); end
        @(negedge clk); freeze = 0; #1;
        nvec++; if ({rq1_waitrequest, rq0_waitrequest} !== 2'b01) begin nerr++; $display("FAIL frz_post got %b want 01", {rq1_waitrequest, rq0_waitrequest}); end
        @(negedge clk); idle();
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        rq0_read = 1; rq0_address = 15'h0010; #1;
        nvec++; if (rq0_waitrequest !== 1'b0) begin nerr++; $display("FAIL mrst_grant got %b want 0", rq0_waitrequest); end
        #3 reset = 1;
        @(negedge clk); #1;
        nvec++; if ({rq1_readdatavalid, rq0_readdatavalid} !== 2'b00) begin nerr++; $display("FAIL mrst_rdv got %b want 00", {rq1_readdatavalid, rq0_readdatavalid}); end
        nvec++; if ({grant_cnt0, grant_cnt1} !== 32'h0) begin nerr++; $display("FAIL mrst_cnt got %h want 0", {grant_cnt0, grant_cnt1}); end
        nvec++; if ({rq0_waitrequest, rq1_waitrequest, mem_chipselect, mem_write, mem_clken} !== 5'b11000)
            begin nerr++; $display("FAIL mrst_out got %b want 11000", {rq0_waitrequest, rq1_waitrequest, mem_chipselect, mem_write, mem_clken}); end
        @(negedge clk); reset = 0; idle(); #1;
        nvec++; if ({rq1_readdatavalid, rq0_readdatavalid} !== 2'b00) begin nerr++; $display("FAIL mrst_after got %b want 00", {rq1_readdatavalid, rq0_readdatavalid}); end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        rq0_read = 1; rq0_address = 15'h0010;
        for (int i = 0; i < 65534; i++) @(negedge clk);
        #1;
        nvec++; if (grant_cnt0 !== 16'hFFFE) begin nerr++; $display("FAIL sat_pre got %h want fffe", grant_cnt0); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            nvec++; if (grant_cnt0 !== 16'hFFFF) begin nerr++; $display("FAIL sat[%0d] got %h want ffff", i, grant_cnt0); end
        end
        nvec++; if (grant_cnt1 !== 16'h0) begin nerr++; $display("FAIL sat_cnt1 got %h want 0", grant_cnt1); end
        idle();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byteenable();
        test_alternate();
        test_freeze();
        test_reset_mid_read();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
